// File: rtl/decode_stage_if.sv
// Fetch-to-decode bus plus the select/immediate outputs
// that fan out to the one-hot register file and EX.
interface decode_stage_if;
    logic [31:0] ibus;
    logic        stall;
    logic        flush;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] Dselect;
    logic        Imm;
    logic [31:0] immval;

    modport master (
        output ibus, stall, flush,
        input  Aselect, Bselect, Dselect, Imm, immval
    );

    modport slave (
        input  ibus, stall, flush,
        output Aselect, Bselect, Dselect, Imm, immval
    );
endinterface

// File: rtl/decode_stage.sv
// IF/ID register, one-hot rs/rt/rd decode and the destination
// select pipeline that lands Dselect in the writeback cycle.
module decode_stage #(
    parameter int WB_STAGES = 3
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [31:0]                ir_q, ir_d;
    logic [WB_STAGES-1:0][31:0] dsel_q, dsel_d;
    logic                       imm_q, imm_d;
    logic [31:0]                immval_q, immval_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        is_r, is_sw, is_br;
    logic [31:0] dsel_id;

    function automatic logic [31:0] dec5(input logic [4:0] f);
        return 32'h1 << f;
    endfunction

    assign op = ir_q[31:26];
    assign rs = ir_q[25:21];
    assign rt = ir_q[20:16];
    assign rd = ir_q[15:11];

    always_comb begin
        is_r  = 1'b0;
        is_sw = 1'b0;
        is_br = 1'b0;
        unique case (op)
            OP_RTYPE:       is_r  = 1'b1;
            OP_SW:          is_sw = 1'b1;
            OP_BEQ, OP_BNE: is_br = 1'b1;
            default:        ;
        endcase
    end

    // Stores and branches name a destination slot 0, which the regfile drops
    always_comb begin
        dsel_id = dec5(rt);
        if (is_r)
            dsel_id = dec5(rd);
        else if (is_sw || is_br)
            dsel_id = 32'h1;
    end

    assign bus.Aselect = dec5(rs);
    assign bus.Bselect = (is_r || is_sw || is_br) ? dec5(rt) : 32'h1;
    assign bus.Dselect = dsel_q[WB_STAGES-1];
    assign bus.Imm     = imm_q;
    assign bus.immval  = immval_q;

    always_comb begin
        ir_d     = ir_q;
        dsel_d   = dsel_q;
        imm_d    = imm_q;
        immval_d = immval_q;

        if (bus.flush)
            ir_d = '0;
        else if (!bus.stall)
            ir_d = bus.ibus;

        // A stall always bubbles ID/EX, even when a flush clears IF/ID
        if (bus.stall) begin
            dsel_d[0] = 32'h1;
            imm_d     = 1'b0;
            immval_d  = '0;
        end else begin
            dsel_d[0] = dsel_id;
            imm_d     = !(is_r || is_br);
            immval_d  = {{16{ir_q[15]}}, ir_q[15:0]};
        end

        for (int i = 1; i < WB_STAGES; i++)
            dsel_d[i] = dsel_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q     <= '0;
            dsel_q   <= {WB_STAGES{32'h1}};
            imm_q    <= 1'b0;
            immval_q <= '0;
        end else begin
            ir_q     <= ir_d;
            dsel_q   <= dsel_d;
            imm_q    <= imm_d;
            immval_q <= immval_d;
        end
    end
endmodule
